// File: rtl/i2c_entity.sv
// rtl/i2c_entity.sv - I2C master for 16-bit register-addressed writes and reads
// Purpose: issues START, {addr,W}, register high/low bytes, then either write
//   data bytes or a repeated START, {addr,R} and received bytes, then STOP.
//   Each bit is four quarters of CLKS_PER_QUARTER clocks. Lines are open-drain:
//   the pad drive value is always 0 and only the tristate controls change.
// Optional feature: define I2C_CLOCK_STRETCH_EN to let a slave stretch SCL
//   (the high phase waits until SCL_out reads back high).
// Ports:
//   clock, reset              system clock, synchronous active-high reset
//   start, ready              transaction request / idle indication
//   slave_adress, register_address, is_read, nb_of_bytes  transaction setup
//   data_in                   write data, sampled as each write byte begins
//   SCL_out, SDA_out          pad readback
//   SCL_in, SDA_in            pad drive value (constant 0)
//   SCL_t, SDA_t              tristate control, 1 = release, 0 = pull low
//   data_out                  last two received bytes, newest in [7:0]
//   error_out                 last transaction aborted on a slave NACK
module i2c_entity #(
    parameter int CLKS_PER_QUARTER = 250
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [6:0]  slave_adress,
    input  logic [15:0] register_address,
    input  logic        is_read,
    input  logic [9:0]  nb_of_bytes,
    input  logic [7:0]  data_in,
    input  logic        SCL_out,
    input  logic        SDA_out,
    output logic        SCL_in,
    output logic        SDA_in,
    output logic        SCL_t,
    output logic        SDA_t,
    output logic [15:0] data_out,
    output logic        ready,
    output logic        error_out
);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_ADDR_W, S_REG_HI, S_REG_LO,
        S_WR_DATA, S_RSTART, S_ADDR_R, S_RD_DATA, S_STOP
    } state_t;

    localparam logic [15:0] QEND = 16'(CLKS_PER_QUARTER - 1);

    state_t      state;
    logic [15:0] cnt;
    logic [1:0]  quarter;
    logic [3:0]  bit_idx;       // 0..7 data bits, 8 = acknowledge bit
    logic [6:0]  addr_q;
    logic [15:0] reg_q;
    logic        read_q;
    logic [9:0]  bytes_left;
    logic [7:0]  tx_shift;
    logic [6:0]  rx_shift;
    logic        nack;

    logic        is_tx;
    logic        is_rx;
    logic        is_cond;
    logic        last_byte;
    logic        q_start;
    logic        q_end;
    logic        stretch_hold;
    logic [7:0]  tx_byte;

    assign SCL_in = 1'b0;
    assign SDA_in = 1'b0;

    always_comb begin
        is_tx     = (state == S_ADDR_W) || (state == S_REG_HI) || (state == S_REG_LO) ||
                    (state == S_WR_DATA) || (state == S_ADDR_R);
        is_rx     = (state == S_RD_DATA);
        is_cond   = (state == S_START) || (state == S_RSTART);
        last_byte = (bytes_left == 10'd1);
        q_start   = (cnt == 16'd0);
        q_end     = (cnt == QEND);
        tx_byte   = 8'h00;
        case (state)
            S_ADDR_W:  tx_byte = {addr_q, 1'b0};
            S_REG_HI:  tx_byte = reg_q[15:8];
            S_REG_LO:  tx_byte = reg_q[7:0];
            S_WR_DATA: tx_byte = data_in;
            S_ADDR_R:  tx_byte = {addr_q, 1'b1};
            default:   tx_byte = 8'h00;
        endcase
    end

`ifdef I2C_CLOCK_STRETCH_EN
    // SCL was released at the first cycle of Q1; while the slave still holds
    // it low, park the count so the high phase is timed from the release.
    assign stretch_hold = (quarter == 2'd1) && (cnt != 16'd0) && !SCL_out;
`else
    logic unused_scl_out;
    assign unused_scl_out = SCL_out;
    assign stretch_hold   = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            quarter    <= '0;
            bit_idx    <= '0;
            addr_q     <= '0;
            reg_q      <= '0;
            read_q     <= 1'b0;
            bytes_left <= '0;
            tx_shift   <= '0;
            rx_shift   <= '0;
            nack       <= 1'b0;
            SCL_t      <= 1'b1;
            SDA_t      <= 1'b1;
            data_out   <= '0;
            ready      <= 1'b1;
            error_out  <= 1'b0;
        end else if (state == S_IDLE) begin
            SCL_t <= 1'b1;
            SDA_t <= 1'b1;
            if (start) begin
                addr_q     <= slave_adress;
                reg_q      <= register_address;
                read_q     <= is_read;
                bytes_left <= nb_of_bytes;
                error_out  <= 1'b0;
                ready      <= 1'b0;
                nack       <= 1'b0;
                cnt        <= '0;
                quarter    <= '0;
                bit_idx    <= '0;
                state      <= S_START;
            end
        end else begin
            if (stretch_hold) begin
                cnt <= 16'd1;
            end else if (q_end) begin
                cnt     <= '0;
                quarter <= quarter + 2'd1;
            end else begin
                cnt <= cnt + 16'd1;
            end

            // Line actions happen on the first cycle of each quarter.
            if (q_start) begin
                case (quarter)
                    2'd0: begin
                        if (is_cond) begin
                            SDA_t <= 1'b1;          // SCL left as is: high from idle, low mid-frame
                        end else if (state == S_STOP) begin
                            SCL_t <= 1'b0;
                            SDA_t <= 1'b0;
                        end else if (is_tx) begin
                            SCL_t <= 1'b0;
                            if (bit_idx == 4'd8) begin
                                SDA_t <= 1'b1;
                            end else if (bit_idx == 4'd0) begin
                                SDA_t    <= tx_byte[7];
                                tx_shift <= {tx_byte[6:0], 1'b0};
                            end else begin
                                SDA_t    <= tx_shift[7];
                                tx_shift <= {tx_shift[6:0], 1'b0};
                            end
                        end else begin
                            SCL_t <= 1'b0;
                            // Master ACKs every received byte but NACKs the last one.
                            SDA_t <= (bit_idx == 4'd8) ? last_byte : 1'b1;
                        end
                    end
                    2'd1: SCL_t <= 1'b1;
                    2'd2: begin
                        if (is_cond) begin
                            SDA_t <= 1'b0;
                        end else if (state == S_STOP) begin
                            SDA_t <= 1'b1;
                        end else if (is_tx && (bit_idx == 4'd8)) begin
                            nack <= SDA_out;
                        end else if (is_rx && (bit_idx != 4'd8)) begin
                            rx_shift <= {rx_shift[5:0], SDA_out};
                            if (bit_idx == 4'd7) begin
                                data_out <= {data_out[7:0], rx_shift, SDA_out};
                            end
                        end
                    end
                    default: begin
                        if (state != S_STOP) begin
                            SCL_t <= 1'b0;
                        end
                    end
                endcase
            end

            if (q_end && (quarter == 2'd3)) begin
                case (state)
                    S_START:  state <= S_ADDR_W;
                    S_RSTART: state <= S_ADDR_R;
                    S_STOP: begin
                        state <= S_IDLE;
                        ready <= 1'b1;
                        SCL_t <= 1'b1;
                        SDA_t <= 1'b1;
                    end
                    default: begin
                        if (bit_idx != 4'd8) begin
                            bit_idx <= bit_idx + 4'd1;
                        end else begin
                            bit_idx <= '0;
                            if (is_tx && nack) begin
                                state     <= S_STOP;
                                error_out <= 1'b1;
                            end else begin
                                case (state)
                                    S_ADDR_W: state <= S_REG_HI;
                                    S_REG_HI: state <= S_REG_LO;
                                    S_REG_LO: begin
                                        if (bytes_left == 10'd0) begin
                                            state <= S_STOP;
                                        end else if (read_q) begin
                                            state <= S_RSTART;
                                        end else begin
                                            state <= S_WR_DATA;
                                        end
                                    end
                                    S_ADDR_R: state <= S_RD_DATA;
                                    default: begin
                                        bytes_left <= bytes_left - 10'd1;
                                        if (last_byte) begin
                                            state <= S_STOP;
                                        end
                                    end
                                endcase
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_entity.sv
// tb/tb_i2c_entity.sv - directed vector bench for i2c_entity with a bus-level slave
module tb_i2c_entity;

    localparam int CPQ = 4;
    localparam logic [9:0] S = 10'h100;
    localparam logic [9:0] P = 10'h200;
    localparam logic [9:0] X = 10'h3FF;

    logic        clock;
    logic        reset;
    logic        start;
    logic [6:0]  slave_adress;
    logic [15:0] register_address;
    logic        is_read;
    logic [9:0]  nb_of_bytes;
    logic [7:0]  data_in;
    logic        SCL_out;
    logic        SDA_out;
    logic        SCL_in;
    logic        SDA_in;
    logic        SCL_t;
    logic        SDA_t;
    logic [15:0] data_out;
    logic        ready;
    logic        error_out;

    logic slave_sda;
    logic slave_scl_hold;

    assign SCL_out = SCL_t & ~slave_scl_hold;
    assign SDA_out = SDA_t & slave_sda;

    i2c_entity #(.CLKS_PER_QUARTER(CPQ)) dut (
        .clock(clock), .reset(reset), .start(start),
        .slave_adress(slave_adress), .register_address(register_address),
        .is_read(is_read), .nb_of_bytes(nb_of_bytes), .data_in(data_in),
        .SCL_out(SCL_out), .SDA_out(SDA_out), .SCL_in(SCL_in), .SDA_in(SDA_in),
        .SCL_t(SCL_t), .SDA_t(SDA_t), .data_out(data_out),
        .ready(ready), .error_out(error_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Slave model: logs START/STOP and every byte the master sends, ACKs
    // unless told to NACK, and returns rd_bytes after an {addr,R} byte.
    logic [9:0] bus_log[$];
    logic       mack_log[$];
    int         m_idx;
    int         nack_at;
    logic [7:0] rd_bytes [0:1];
    int         s_bit;
    logic       s_tx, s_first, m_acked, prev_scl, prev_sda, cur_scl, cur_sda;
    logic [7:0] s_sh, rd_cur;
    int         rd_idx;

    initial begin
        slave_sda = 1'b1; slave_scl_hold = 1'b0; prev_scl = 1'b1; prev_sda = 1'b1;
        s_bit = 0; s_tx = 1'b0; s_first = 1'b0; m_acked = 1'b0; s_sh = 8'h00;
        rd_cur = 8'hFF; rd_idx = 0; m_idx = 0; nack_at = 99;
        forever begin
            @(negedge clock);
            cur_scl = SCL_t & ~slave_scl_hold;
            cur_sda = SDA_t & slave_sda;
            if (reset) begin
                slave_sda = 1'b1; s_bit = 0; s_tx = 1'b0; s_first = 1'b0;
            end else if (cur_scl && prev_scl && prev_sda && !cur_sda) begin
                bus_log.push_back(S); s_bit = -1; s_tx = 1'b0; s_first = 1'b1;
            end else if (cur_scl && prev_scl && !prev_sda && cur_sda) begin
                bus_log.push_back(P); s_bit = 0; s_tx = 1'b0; slave_sda = 1'b1;
            end else if (cur_scl && !prev_scl) begin
                if (s_bit >= 0 && s_bit < 8) begin
                    s_sh = {s_sh[6:0], cur_sda};
                end else if (s_bit == 8 && s_tx) begin
                    mack_log.push_back(cur_sda);
                    m_acked = !cur_sda;
                end
            end else if (!cur_scl && prev_scl) begin
                if (s_bit < 0) begin
                    s_bit = 0;
                end else if (s_bit < 8) begin
                    s_bit++;
                    if (s_bit == 8) begin
                        if (s_tx) begin
                            slave_sda = 1'b1;
                        end else begin
                            bus_log.push_back({2'b00, s_sh});
                            slave_sda = (m_idx == nack_at);
                            m_idx++;
                        end
                    end else if (s_tx) begin
                        slave_sda = rd_cur[7 - s_bit];
                    end
                end else begin
                    s_bit = 0;
                    slave_sda = 1'b1;
                    if (!s_tx && s_first && s_sh[0]) begin
                        s_tx = 1'b1; rd_idx = 0; m_acked = 1'b1;
                    end
                    s_first = 1'b0;
                    if (s_tx && m_acked) begin
                        rd_cur = (rd_idx < 2) ? rd_bytes[rd_idx] : 8'hFF;
                        rd_idx++;
                        slave_sda = rd_cur[7];
                    end
                end
            end
            prev_scl = SCL_t & ~slave_scl_hold;
            prev_sda = SDA_t & slave_sda;
        end
    end

    typedef struct {
        logic [6:0]       addr;
        logic [15:0]      regad;
        logic             rd;
        logic [9:0]       nb;
        logic [7:0]       din;
        int               nack_at;
        logic [7:0]       rd0;
        logic [7:0]       rd1;
        logic             busy;
        int               n_log;
        logic [0:9][9:0]  lg;
        int               n_mack;
        logic [1:0]       mack;
        logic             err;
        logic [15:0]      dout;
    } vec_t;

    vec_t vec [0:7];

    task automatic wait_ready(input string name);
        int n = 0;
        while (!ready && n < 6000) begin
            @(negedge clock);
            n++;
        end
        check({name, "_ready"}, ready, 1'b1);
    endtask

    task automatic begin_txn(input int i);
        @(negedge clock);
        bus_log.delete(); mack_log.delete();
        m_idx = 0; nack_at = vec[i].nack_at;
        rd_bytes[0] = vec[i].rd0; rd_bytes[1] = vec[i].rd1;
        slave_adress = vec[i].addr; register_address = vec[i].regad;
        is_read = vec[i].rd; nb_of_bytes = vec[i].nb; data_in = vec[i].din;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic check_result(input int i);
        logic [9:0] act;
        check($sformatf("v%0d_log_len", i), bus_log.size(), vec[i].n_log);
        for (int k = 0; k < vec[i].n_log; k++) begin
            act = (k < bus_log.size()) ? bus_log[k] : 10'h3FE;
            check($sformatf("v%0d_log%0d", i, k), act, vec[i].lg[k]);
        end
        check($sformatf("v%0d_mack_len", i), mack_log.size(), vec[i].n_mack);
        for (int k = 0; k < vec[i].n_mack; k++) begin
            check($sformatf("v%0d_mack%0d", i, k),
                  (k < mack_log.size()) ? mack_log[k] : 1'bx, vec[i].mack[k]);
        end
        check($sformatf("v%0d_error", i), error_out, vec[i].err);
        check($sformatf("v%0d_data_out", i), data_out, vec[i].dout);
        check($sformatf("v%0d_lines_idle", i), {SCL_t, SDA_t}, 2'b11);
    endtask

    task automatic run_vec(input int i);
        begin_txn(i);
        check($sformatf("v%0d_busy", i), ready, 1'b0);
        check($sformatf("v%0d_err_clear", i), error_out, 1'b0);
        if (vec[i].busy) begin
            repeat (100) @(negedge clock);
            slave_adress = 7'h01; register_address = 16'h0000;
            is_read = 1'b1; nb_of_bytes = 10'd5; start = 1'b1;
            @(negedge clock);
            start = 1'b0;
        end
        wait_ready($sformatf("v%0d", i));
        check_result(i);
    endtask

    initial begin
        int n;
        logic seen_high;
        vec[0] = '{7'h11, 16'h0102, 1'b0, 10'd1, 8'hA5, 99, 8'h00, 8'h00, 1'b0,
                   6, {S, 10'h22, 10'h01, 10'h02, 10'hA5, P, X, X, X, X}, 0, 2'b00, 1'b0, 16'h0000};
        vec[1] = '{7'h11, 16'h00E5, 1'b1, 10'd2, 8'h00, 99, 8'h12, 8'h34, 1'b0,
                   7, {S, 10'h22, 10'h00, 10'hE5, S, 10'h23, P, X, X, X}, 2, 2'b10, 1'b0, 16'h1234};
        vec[2] = '{7'h11, 16'h0102, 1'b0, 10'd1, 8'hA5, 0, 8'h00, 8'h00, 1'b0,
                   3, {S, 10'h22, P, X, X, X, X, X, X, X}, 0, 2'b00, 1'b1, 16'h1234};
        vec[3] = '{7'h3C, 16'hBEEF, 1'b1, 10'd0, 8'h00, 99, 8'h00, 8'h00, 1'b0,
                   5, {S, 10'h78, 10'hBE, 10'hEF, P, X, X, X, X, X}, 0, 2'b00, 1'b0, 16'h1234};
        vec[4] = '{7'h50, 16'hA0B1, 1'b0, 10'd2, 8'h5A, 99, 8'h00, 8'h00, 1'b1,
                   7, {S, 10'hA0, 10'hA0, 10'hB1, 10'h5A, 10'h5A, P, X, X, X}, 0, 2'b00, 1'b0, 16'h1234};
        vec[5] = '{7'h50, 16'hA0B1, 1'b0, 10'd3, 8'hC3, 2, 8'h00, 8'h00, 1'b0,
                   5, {S, 10'hA0, 10'hA0, 10'hB1, P, X, X, X, X, X}, 0, 2'b00, 1'b1, 16'h1234};
        vec[6] = '{7'h7F, 16'hFFFF, 1'b1, 10'd1, 8'h00, 99, 8'h80, 8'h00, 1'b0,
                   7, {S, 10'hFE, 10'hFF, 10'hFF, S, 10'hFF, P, X, X, X}, 1, 2'b01, 1'b0, 16'h3480};
        vec[7] = '{7'h11, 16'h0102, 1'b0, 10'd1, 8'hA5, 99, 8'h00, 8'h00, 1'b0,
                   6, {S, 10'h22, 10'h01, 10'h02, 10'hA5, P, X, X, X, X}, 0, 2'b00, 1'b0, 16'h0000};

        reset = 1'b1; start = 1'b0; slave_adress = '0; register_address = '0;
        is_read = 1'b0; nb_of_bytes = '0; data_in = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("rst_scl_t", SCL_t, 1'b1);
        check("rst_sda_t", SDA_t, 1'b1);
        check("rst_ready", ready, 1'b1);
        check("rst_error", error_out, 1'b0);
        check("rst_data_out", data_out, 16'h0000);
        check("rst_pad_drive", {SCL_in, SDA_in}, 2'b00);

        for (int i = 0; i < 7; i++) begin
            run_vec(i);
        end

        // Reset in the middle of the REG_LO byte.
        begin_txn(7);
        n = 0;
        while (bus_log.size() < 3 && n < 3000) begin @(negedge clock); n++; end
        while (s_bit != 3 && n < 3000) begin @(negedge clock); n++; end
        check("midrst_reached_reg_lo", (bus_log.size() == 3 && s_bit == 3), 1'b1);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_scl_t", SCL_t, 1'b1);
        check("midrst_sda_t", SDA_t, 1'b1);
        check("midrst_ready", ready, 1'b1);
        check("midrst_error", error_out, 1'b0);
        check("midrst_data_out", data_out, 16'h0000);
        @(negedge clock);
        reset = 1'b0;
        run_vec(7);

        // Slave holds SCL low through the address ACK bit.
        begin_txn(0);
        n = 0;
        while (bus_log.size() < 2 && n < 3000) begin @(negedge clock); n++; end
        check("hold_addr_seen", bus_log.size() >= 2, 1'b1);
        slave_scl_hold = 1'b1;
`ifdef I2C_CLOCK_STRETCH_EN
        repeat (1000) @(negedge clock);
        check("stretch_released_by_master", SCL_t, 1'b1);
        slave_scl_hold = 1'b0;
        n = 0;
        while (SCL_t && n < 100) begin @(negedge clock); n++; end
        check("stretch_high_phase", n, 2 * CPQ);
        wait_ready("stretch");
        check_result(0);
`else
        n = 0;
        seen_high = 1'b0;
        while (n < 100 && !(seen_high && !SCL_t)) begin
            @(negedge clock);
            n++;
            if (SCL_t) seen_high = 1'b1;
        end
        check("fixed_timing_ignores_scl", (n <= 20), 1'b1);
        slave_scl_hold = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check("fixed_after_reset_ready", ready, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1);
    end

endmodule

// File: doc/i2c_entity.md
I2C_ENTITY -- requirements
Module: i2c_entity

Interface
REQ-001 SHALL have parameter CLKS_PER_QUARTER, default 250, meaning clock cycles per quarter SCL bit period (100 kHz at 100 MHz).
REQ-002 SHALL have clock  input  1  system clock; one clock domain, all logic on its rising edge.
REQ-003 SHALL have reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have start  input  1  transaction request, accepted only while ready=1.
REQ-005 SHALL have slave_adress  input  7  7-bit target address.
REQ-006 SHALL have register_address  input  16  target register, sent MSB byte first.
REQ-007 SHALL have is_read  input  1  1=read transaction, 0=write.
REQ-008 SHALL have nb_of_bytes  input  10  data byte count, 0..1023.
REQ-009 SHALL have data_in  input  8  write data byte.
REQ-010 SHALL have SCL_out, SDA_out  input  1 each  pad readback from the IOBUF O pins.
REQ-011 SHALL have SCL_in, SDA_in  output  1 each  pad drive value to the IOBUF I pins; constant 0 (open-drain).
REQ-012 SHALL have SCL_t, SDA_t  output  1 each  tristate control; 1=release (line high), 0=pull low.
REQ-013 SHALL have data_out  output  16  last two bytes read, most recent byte in [7:0].
REQ-014 SHALL have ready  output  1  1=idle, able to accept start.
REQ-015 SHALL have error_out  output  1  1=last transaction aborted on NACK.

Function
REQ-016 SHALL, in IDLE with start=1, latch slave_adress, register_address, is_read and nb_of_bytes, clear error_out and drive ready=0 on the next edge; start while ready=0 SHALL be ignored.
REQ-017 SHALL time every bit as four quarters of CLKS_PER_QUARTER cycles: Q0 SCL low with SDA updated; Q1 SCL released; Q2 SDA sampled while SCL high; Q3 SCL pulled low.
REQ-018 SHALL generate START as SDA falling while SCL is high, and STOP as SDA rising while SCL is high.
REQ-019 SHALL run states IDLE, START, ADDR_W, REG_HI, REG_LO, WR_DATA, RSTART, ADDR_R, RD_DATA, STOP; each transmitted byte SHALL be 8 bits MSB first followed by a 9th ACK bit with SDA released.
REQ-020 SHALL, on write: START, {addr,0}, REG_HI, REG_LO, then nb_of_bytes bytes of data_in (data_in sampled at Q0 of each byte's first bit), then STOP.
REQ-021 SHALL, on read with nb_of_bytes>=1: START, {addr,0}, REG_HI, REG_LO, repeated START, {addr,1}, then nb_of_bytes received bytes, master ACK after every byte except the last, NACK after the last, then STOP.
REQ-022 SHALL update data_out after each received byte as {data_out[7:0], byte}.
REQ-023 SHALL treat nb_of_bytes=0 as address-only: START, {addr,0}, REG_HI, REG_LO, STOP, regardless of is_read.
REQ-024 SHALL, on a NACK (SDA=1 at Q2 of any slave ACK bit), go directly to STOP, set error_out=1, and skip the remaining bytes.
REQ-025 SHALL assert ready=1 one clock after STOP completes (SDA released); error_out SHALL hold until the next accepted start.
REQ-026 SHALL never drive either line high; both lines SHALL be released (T=1) while in IDLE.

Reset
REQ-027 SHALL, on reset=1 at any time including mid-transfer, on the next edge: go to IDLE, set SCL_t=1, SDA_t=1, ready=1, error_out=0, data_out=16'h0000, and clear all counters; no STOP is generated.

Configuration
REQ-028 SHALL, when I2C_CLOCK_STRETCH_EN is defined, hold in Q1 after SCL release until SCL_out=1 (slave clock stretching), restarting the quarter count from that point.
REQ-029 SHALL, when I2C_CLOCK_STRETCH_EN is undefined, ignore SCL_out and use fixed quarter timing.

Verification
REQ-030 Write: addr 0x11, reg 0x0102, nb=1, data_in 0xA5, slave ACKs all -> bus bytes 0x22,0x01,0x02,0xA5 then STOP; ready=1; error_out=0.
REQ-031 Read: addr 0x11, reg 0x00E5, nb=2, slave returns 0x12,0x34 -> bus bytes 0x22,0x00,0xE5, repeated START, 0x23; master sends ACK then NACK; data_out=0x1234.
REQ-032 NACK on address byte 0x22 -> STOP immediately after the ACK bit, no register bytes sent, error_out=1, ready=1.
REQ-033 Reset asserted mid-byte during REG_LO -> next edge SCL_t=SDA_t=1, ready=1, data_out=0x0000; a new start then runs normally.
REQ-034 start pulsed while ready=0 -> ignored, current transaction's byte sequence unchanged; nb=0 -> address-only sequence 0x22,hi,lo,STOP.
REQ-035 With I2C_CLOCK_STRETCH_EN, slave holds SCL low for 1000 cycles during the ACK bit -> SCL high phase starts only after release, and data is unchanged.
